// File: rtl/ram_arbiter.sv
`default_nettype none
// ram_arbiter: round-robin arbiter that serialises instruction fetch (port 0) and
// data load/store (port 1) accesses onto one shared RAM with a fixed access latency.
module ram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              gnt0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LAT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;

  logic             we_q, we_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             cs_q, cs_d;
  logic             rwe_q, rwe_d;
  logic             oe_q, oe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic sel;
  logic start;
  logic done;

  // On a tie the port that did not win last time is chosen.
  assign sel   = (req0 && req1) ? ~last_q : req1;
  assign start = (state_q == S_IDLE) && (req0 || req1);
  assign done  = (state_q == S_ACCESS) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_LOAD;
          owner_d = sel;
          last_d  = sel;
        end
      end
      S_ACCESS: begin
        if (done) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;

    if (start) begin
      gnt0_d  = ~sel;
      gnt1_d  = sel;
      we_d    = sel ? we1    : we0;
      addr_d  = sel ? addr1  : addr0;
      wdata_d = sel ? wdata1 : wdata0;
    end

    if (done) begin
      ack0_d = ~owner_q;
      ack1_d = owner_q;
      if (!we_q) begin
        rdata_d = ram_rdata;
      end
    end

    if (state_q == S_RESP) begin
      gnt0_d = 1'b0;
      gnt1_d = 1'b0;
    end

    // Strobes follow the next state so they are registered like every other output.
    busy_d = (state_d != S_IDLE);
    cs_d   = (state_d == S_ACCESS);
    rwe_d  = cs_d & we_d;
    oe_d   = cs_d & ~we_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b0;
      rwe_q   <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      we_q    <= we_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      rwe_q   <= rwe_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;
  assign ram_cs    = cs_q;
  assign ram_we    = rwe_q;
  assign ram_oe    = oe_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign rdata     = rdata_q;

  a_gnt_excl: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));
  a_ack_excl: assert property (@(posedge clk) disable iff (!rst_n) !(ack0 && ack1));
  a_we_oe:    assert property (@(posedge clk) disable iff (!rst_n) !(ram_we && ram_oe));
  a_ack0_gnt: assert property (@(posedge clk) disable iff (!rst_n) ack0 |-> gnt0);
  a_ack1_gnt: assert property (@(posedge clk) disable iff (!rst_n) ack1 |-> gnt1);

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// tb_ram_arbiter: directed stimulus with a transaction-level model checked every
// cycle, plus literal expectations for a RAM_LAT=3 instance.
module tb_ram_arbiter;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ack0, gnt0, ack1, gnt1, busy, ram_cs, ram_we, ram_oe;
  logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic [31:0] mem [256];

  logic        r3_req0 = 1'b0, r3_we0 = 1'b0, r3_req1 = 1'b0, r3_we1 = 1'b0;
  logic [31:0] r3_addr0 = '0, r3_wdata0 = '0, r3_addr1 = '0, r3_wdata1 = '0;
  logic        r3_ack0, r3_gnt0, r3_ack1, r3_gnt1, r3_busy, r3_cs, r3_we, r3_oe;
  logic [31:0] r3_rdata, r3_addr, r3_wdata;
  logic [31:0] rd3 = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .gnt0(gnt0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .gnt1(gnt1),
    .rdata(rdata), .busy(busy), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0(r3_req0), .we0(r3_we0), .addr0(r3_addr0), .wdata0(r3_wdata0), .ack0(r3_ack0), .gnt0(r3_gnt0),
    .req1(r3_req1), .we1(r3_we1), .addr1(r3_addr1), .wdata1(r3_wdata1), .ack1(r3_ack1), .gnt1(r3_gnt1),
    .rdata(r3_rdata), .busy(r3_busy), .ram_cs(r3_cs), .ram_we(r3_we), .ram_oe(r3_oe),
    .ram_addr(r3_addr), .ram_wdata(r3_wdata), .ram_rdata(rd3)
  );

  // Bench RAM, driven only by the DUT's RAM pins.
  assign ram_rdata = mem[ram_addr[7:0]];
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr[7:0]] = ram_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction model: age counts edges since the grant (0 = no access in flight).
  int          age = 0;
  bit          m_own = 1'b0, m_last = 1'b1, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [31:0] mmem [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age = 0; m_own = 1'b0; m_last = 1'b1; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (age == 0) begin
      if (req0 || req1) begin
        m_own   = (req0 && req1) ? !m_last : req1;
        m_last  = m_own;
        m_we    = m_own ? we1 : we0;
        m_addr  = m_own ? addr1 : addr0;
        m_wdata = m_own ? wdata1 : wdata0;
        age     = 1;
      end
    end else begin
      if (age == LAT) begin
        if (m_we) mmem[m_addr[7:0]] = m_wdata;
        else      m_rdata = mmem[m_addr[7:0]];
      end
      age = (age == LAT + 1) ? 0 : age + 1;
    end
  end

  logic [7:0] exp_flags, act_flags;
  bit         e_cs;

  always @(negedge clk) begin
    e_cs      = (age >= 1) && (age <= LAT);
    exp_flags = {(age != 0) && !m_own, (age != 0) && m_own,
                 (age == LAT + 1) && !m_own, (age == LAT + 1) && m_own,
                 age != 0, e_cs, e_cs && m_we, e_cs && !m_we};
    act_flags = {gnt0, gnt1, ack0, ack1, busy, ram_cs, ram_we, ram_oe};
    chk("flags{gnt0,gnt1,ack0,ack1,busy,cs,we,oe}", 32'(act_flags), 32'(exp_flags));
    chk("rdata", rdata, m_rdata);
    chk("we_oe_exclusive", 32'(ram_we && ram_oe), 32'd0);
    if (e_cs) chk("ram_addr", ram_addr, m_addr);
    if (e_cs && m_we) chk("ram_wdata", ram_wdata, m_wdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit exp_order [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  bit order [$];
  int at [$];
  bit pb;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0; mmem[i] = 32'h0;
    end
    mem[8'h10] = 32'h00A00093; mmem[8'h10] = 32'h00A00093;
    mem[8'h20] = 32'h22222222; mmem[8'h20] = 32'h22222222;
    mem[8'h40] = 32'h40404040; mmem[8'h40] = 32'h40404040;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_flags", 32'({gnt0, gnt1, ack0, ack1, busy, ram_cs, ram_we, ram_oe}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    chk("rst3_flags", 32'({r3_gnt0, r3_gnt1, r3_ack0, r3_ack1, r3_busy, r3_cs, r3_we, r3_oe}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single read on port 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    tick();
    chk("rd_cs_oe", 32'({ram_cs, ram_oe, ram_we}), 32'b110);
    chk("rd_addr", ram_addr, 32'h10);
    chk("rd_gnt0", 32'(gnt0), 32'd1);
    tick();
    chk("rd_ack0", 32'({ack0, ack1, ram_cs}), 32'b100);
    chk("rd_rdata", rdata, 32'h00A00093);
    req0 = 1'b0;
    tick();
    chk("rd_idle", 32'({busy, gnt0}), 32'd0);

    // Write on port 1, then read it back on port 0
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'hDEADBEEF;
    tick();
    chk("wr_we_oe", 32'({ram_we, ram_oe}), 32'b10);
    chk("wr_wdata", ram_wdata, 32'hDEADBEEF);
    tick();
    chk("wr_ack1", 32'({ack0, ack1}), 32'b01);
    chk("wr_rdata_kept", rdata, 32'h00A00093);
    req1 = 1'b0;
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
    tick(); tick();
    chk("rb_rdata", rdata, 32'hDEADBEEF);
    req0 = 1'b0;
    tick();

    // Both ports requesting continuously after reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40;
    pb = 1'b0;
    for (int k = 0; k < 18; k++) begin
      tick();
      if (busy && !pb) begin
        order.push_back(gnt1);
        at.push_back(k);
      end
      pb = busy;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("rr_grant_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      chk("rr_grant_order", 32'(order[i]), 32'(exp_order[i]));
      if (i > 0) chk("rr_spacing", 32'(at[i] - at[i-1]), 32'd3);
    end

    // Operand change and request withdrawal during ACCESS
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    tick();
    addr0 = 32'h20;
    chk("chg_ram_addr", ram_addr, 32'h10);
    tick();
    chk("chg_ack0", 32'(ack0), 32'd1);
    chk("chg_rdata", rdata, 32'h00A00093);
    req0 = 1'b0;
    tick();
    req0 = 1'b1; addr0 = 32'h10;
    tick();
    req0 = 1'b0;
    chk("wd_ram_addr", ram_addr, 32'h10);
    tick();
    chk("wd_ack0", 32'(ack0), 32'd1);
    tick();
    chk("wd_idle", 32'(busy), 32'd0);

    // RAM_LAT=3 instance: rdata is whatever the RAM drives at the third edge
    r3_req0 = 1'b1; r3_we0 = 1'b0; r3_addr0 = 32'h10; rd3 = 32'hAAAA0000;
    tick();
    chk("l3_cycle1", 32'({r3_cs, r3_oe, r3_ack0, r3_gnt0}), 32'b1101);
    chk("l3_addr", r3_addr, 32'h10);
    rd3 = 32'hAAAA0001;
    tick();
    chk("l3_cycle2", 32'({r3_cs, r3_ack0}), 32'b10);
    rd3 = 32'hAAAA0002;
    tick();
    chk("l3_cycle3", 32'({r3_cs, r3_ack0}), 32'b10);
    rd3 = 32'hAAAA0003;
    tick();
    chk("l3_ack", 32'({r3_cs, r3_ack0, r3_ack1}), 32'b010);
    chk("l3_rdata", r3_rdata, 32'hAAAA0003);
    r3_req0 = 1'b0;
    rd3 = 32'h55555555;
    tick();
    chk("l3_done", 32'({r3_ack0, r3_busy, r3_gnt0}), 32'd0);
    chk("l3_rdata_hold", r3_rdata, 32'hAAAA0003);

    // Asynchronous reset in the middle of an access
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_flags", 32'({gnt0, gnt1, ack0, ack1, busy, ram_cs, ram_we, ram_oe}), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_ram_addr", ram_addr, 32'd0);
    req0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40;
    tick();
    chk("arst_first_gnt", 32'({gnt0, gnt1}), 32'b01);
    tick();
    chk("arst_ack1", 32'(ack1), 32'd1);
    req1 = 1'b0;
    tick();
    req0 = 1'b1; addr0 = 32'h10; req1 = 1'b1;
    tick();
    chk("arst_tie_gnt", 32'({gnt0, gnt1}), 32'b10);
    tick();
    chk("arst_tie_ack0", 32'(ack0), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter for the single shared RAM: port 0 is instruction fetch from the control FSM, port 1 is data load/store (LW/SW states to be added).
- Each port uses a req/ack handshake; the arbiter serialises accesses and drives ram_cs/ram_we/ram_oe.
- Accesses complete after a fixed RAM latency. Arbitration is round-robin.

Parameters:
- ADDR_W, 32, RAM address width.
- DATA_W, 32, RAM data width.
- RAM_LAT, 1, cycles ram_cs is held per access; read data is valid at the last of these edges; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 (fetch) request, held until ack0
- we0  in  1  port 0 write enable (1=write, 0=read)
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- ack0  out  1  port 0 completion pulse, 1 cycle
- gnt0  out  1  port 0 owns the RAM
- req1/we1/addr1/wdata1/ack1/gnt1  same meanings for port 1 (load/store)
- rdata  out  DATA_W  registered read data, valid while ack0 or ack1
- busy  out  1  state != IDLE
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write strobe
- ram_oe  out  1  RAM output enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, cnt=0, last=1 (port 0 wins the first tie). All outputs are 0, including rdata and ram_addr/ram_wdata. Reset mid-access aborts the access with no ack.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE: on an edge with any req high, select a port and latch its we/addr/wdata into the ram_* registers. Go to ACCESS with cnt=RAM_LAT-1 and set the selected gnt.
  - Only one req high: grant that port.
  - Both req high: grant the port != last.
  - Set last = granted port.
- ACCESS:
  - ram_cs=1; ram_oe=~we_latched; ram_we=we_latched; ram_addr/ram_wdata are stable.
  - Each edge decrements cnt. At the edge where cnt==0:
    - capture ram_rdata into rdata (reads only; rdata is unchanged on writes);
    - drop ram_cs/ram_oe/ram_we;
    - go to RESP and assert the owner's ack.
- RESP: ack of the owner is high for exactly this cycle; gnt stays high. The next edge goes to IDLE, clears ack and gnt, and ignores req in this cycle.
- Timing: a req sampled at edge E gives ram_cs high for cycles E..E+RAM_LAT-1 and ack high in the cycle after edge E+RAM_LAT.
  - Per-access occupancy is RAM_LAT+2 cycles, including the mandatory IDLE cycle.
- Requester rules:
  - Hold req and operands until the ack edge.
  - Drop req at the ack edge, or keep it high with new operands to issue back-to-back requests (re-arbitrated in IDLE).
- Request changes or withdrawal during ACCESS/RESP are ignored: operands are already latched, the access completes and ack is still pulsed.
- Invariants: at most one gnt, at most one ack; ram_we and ram_oe are never high together; ack_i implies gnt_i.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1…

Test Plan:
- Reset then single read: RAM word 0x10 = 0x00A00093, req0=1, we0=0, addr0=0x10, RAM_LAT=1 → ram_cs/ram_oe high 1 cycle with ram_addr=0x10; ack0 is 1 cycle later with rdata=0x00A00093; ack1 is never asserted.
- Write on port 1: addr1=0x40, wdata1=0xDEADBEEF, we1=1 → ram_we=1, ram_oe=0, ram_wdata=0xDEADBEEF for 1 cycle; ack1 pulses; rdata is unchanged; a later read of 0x40 returns 0xDEADBEEF.
- Simultaneous requests after reset, held continuously for 6 accesses → grant order 0,1,0,1,0,1; each access takes 3 cycles; there is never an overlapping gnt.
- RAM_LAT=3 read → ram_cs high for exactly 3 cycles; ack 4 cycles after the sampling edge; rdata equals the RAM value present at the 3rd edge.
- Operand change mid-access: change addr0 from 0x10 to 0x20 during ACCESS, and separately drop req0 → ram_addr stays 0x10; ack0 is still pulsed.
- Async reset asserted during ACCESS (between clock edges) → all outputs are 0 immediately, with no ack. After release, req1 alone is granted first, and a subsequent tie goes to port 0.
